// File: rtl/dmref_wr_if.sv
// Raster pixel stream into the reference-frame loader (valid/ready with frame markers).
interface dmref_wr_if #(
  parameter int unsigned DW = 8
) ();
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          s_sof;
  logic          s_eol;

  modport master (output s_valid, output s_data, output s_sof, output s_eol, input s_ready);
  modport slave  (input s_valid, input s_data, input s_sof, input s_eol, output s_ready);
endinterface

// File: rtl/dmref_wr.sv
// Reference-frame write loader: raster pixel stream -> (column,row) pixel writes, one frame per start.
// Optional marker checking (sof/eol vs. counters, sticky err) under `define DMREF_WR_SYNC_CHK_EN.
module dmref_wr #(
  parameter int unsigned FRAME_W = 1920,
  parameter int unsigned FRAME_H = 1080,
  parameter int unsigned AW      = 11,
  parameter int unsigned DW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  dmref_wr_if.slave     pix,
  output logic          wr_en,
  output logic [AW-1:0] waddr_0,
  output logic [AW-1:0] waddr_1,
  output logic [DW-1:0] wdata,
  output logic          err
);

  localparam logic [AW-1:0] XMAX = AW'(FRAME_W - 1);
  localparam logic [AW-1:0] YMAX = AW'(FRAME_H - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t        state, state_nx;
  logic [AW-1:0] x, y, x_nx, y_nx;
  logic [AW-1:0] ex_c, ey_c;
  logic          accept_c, last_c, ready;

  assign pix.s_ready = ready;

`ifdef DMREF_WR_SYNC_CHK_EN
  logic sync_err_c;
`endif

  // Next state, effective write position and counter advance
  always_comb begin
    state_nx = state;
    accept_c = pix.s_valid && (state == LOAD);
    ex_c     = x;
    ey_c     = y;
    x_nx     = x;
    y_nx     = y;
`ifdef DMREF_WR_SYNC_CHK_EN
    sync_err_c = 1'b0;
    if (pix.s_sof && ((x != '0) || (y != '0))) begin
      sync_err_c = 1'b1;
      ex_c       = '0;
      ey_c       = '0;
    end else if (!pix.s_sof && (x == '0) && (y == '0)) begin
      sync_err_c = 1'b1;
    end
    if (pix.s_eol != (ex_c == XMAX)) sync_err_c = 1'b1;
`endif
    last_c = (ex_c == XMAX) && (ey_c == YMAX);

    if (accept_c) begin
      if (last_c) begin
        x_nx = '0;
        y_nx = '0;
      end else if (ex_c == XMAX) begin
        x_nx = '0;
        y_nx = ey_c + AW'(1);
      end else begin
        x_nx = ex_c + AW'(1);
        y_nx = ey_c;
      end
    end
    if ((state == IDLE) && start) begin
      x_nx = '0;
      y_nx = '0;
    end

    unique case (state)
      IDLE:    if (start) state_nx = LOAD;
      LOAD:    if (accept_c && last_c) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, counters and registered outputs; reset drops any pending write
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      x       <= '0;
      y       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ready   <= 1'b0;
      wr_en   <= 1'b0;
      waddr_0 <= '0;
      waddr_1 <= '0;
      wdata   <= '0;
    end else begin
      state <= state_nx;
      x     <= x_nx;
      y     <= y_nx;
      busy  <= (state_nx != IDLE);
      done  <= (state_nx == DONE);
      ready <= (state_nx == LOAD);
      wr_en <= accept_c;
      if (accept_c) begin
        waddr_0 <= ex_c;
        waddr_1 <= ey_c;
        wdata   <= pix.s_data;
      end
    end
  end

`ifdef DMREF_WR_SYNC_CHK_EN
  // Sticky marker error, cleared only by a new frame start or reset
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if ((state == IDLE) && start) begin
      err <= 1'b0;
    end else if (accept_c && sync_err_c) begin
      err <= 1'b1;
    end
  end
`else
  logic sync_unused;
  assign sync_unused = pix.s_sof ^ pix.s_eol;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_dmref_wr.sv
// Scoreboard bench for dmref_wr on an 8x4 frame; expectations follow DMREF_WR_SYNC_CHK_EN when defined.
module tb_dmref_wr;
  localparam int W  = 8;
  localparam int H  = 4;
  localparam int unsigned AW = 11;
  localparam int unsigned DW = 8;
`ifdef DMREF_WR_SYNC_CHK_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  typedef struct { int x; int y; int d; } wr_t;

  logic          clk = 1'b0;
  logic          rst, start, busy, done, wr_en, err;
  logic [AW-1:0] waddr_0, waddr_1;
  logic [DW-1:0] wdata;

  wr_t exp_q[$];
  wr_t obs[$];
  int  m_st, m_x, m_y;
  bit  m_err, exp_wr, mon_en;
  int  n_vec, n_err, done_seen;

  always #5 clk = ~clk;

  dmref_wr_if #(.DW(DW)) pix ();

  dmref_wr #(.FRAME_W(W), .FRAME_H(H), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pix(pix),
    .wr_en(wr_en), .waddr_0(waddr_0), .waddr_1(waddr_1), .wdata(wdata), .err(err)
  );

  // Reference behaviour, evaluated on each rising edge with the inputs the DUT samples
  task automatic model_update();
    int ex, ey;
    exp_wr = 1'b0;
    if (rst) begin
      m_st = 0; m_x = 0; m_y = 0; m_err = 1'b0;
      return;
    end
    case (m_st)
      0: if (start) begin m_st = 1; m_x = 0; m_y = 0; m_err = 1'b0; end
      1: if (pix.s_valid) begin
        ex = m_x; ey = m_y;
        if (SYNC) begin
          if (pix.s_sof && (ex != 0 || ey != 0)) begin m_err = 1'b1; ex = 0; ey = 0; end
          else if (!pix.s_sof && ex == 0 && ey == 0) m_err = 1'b1;
          if (pix.s_eol != (ex == W-1)) m_err = 1'b1;
        end
        exp_q.push_back('{ex, ey, int'(pix.s_data)});
        exp_wr = 1'b1;
        if (ex == W-1 && ey == H-1) begin m_st = 2; m_x = 0; m_y = 0; end
        else if (ex == W-1) begin m_x = 0; m_y = ey + 1; end
        else begin m_x = ex + 1; m_y = ey; end
      end
      default: m_st = 0;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic monitor();
    wr_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        n_vec++;
        if (wr_en !== exp_wr) begin n_err++; $display("FAIL wr_en t=%0t got %b exp %b", $time, wr_en, exp_wr); end
        n_vec++;
        if (busy !== (m_st != 0)) begin n_err++; $display("FAIL busy t=%0t got %b exp %b", $time, busy, m_st != 0); end
        n_vec++;
        if (done !== (m_st == 2)) begin n_err++; $display("FAIL done t=%0t got %b exp %b", $time, done, m_st == 2); end
        n_vec++;
        if (pix.s_ready !== (m_st == 1)) begin n_err++; $display("FAIL s_ready t=%0t got %b exp %b", $time, pix.s_ready, m_st == 1); end
        n_vec++;
        if (err !== m_err) begin n_err++; $display("FAIL err t=%0t got %b exp %b", $time, err, m_err); end
        if (done === 1'b1) done_seen++;
        if (wr_en === 1'b1) begin
          obs.push_back('{int'(waddr_0), int'(waddr_1), int'(wdata)});
          n_vec++;
          if (exp_q.size() == 0) begin
            n_err++; $display("FAIL write t=%0t got unexpected (%0d,%0d)=%0d exp none", $time, waddr_0, waddr_1, wdata);
          end else begin
            e = exp_q.pop_front();
            if (waddr_0 !== AW'(e.x) || waddr_1 !== AW'(e.y) || wdata !== DW'(e.d)) begin
              n_err++;
              $display("FAIL write t=%0t got (%0d,%0d)=%0d exp (%0d,%0d)=%0d",
                       $time, waddr_0, waddr_1, wdata, e.x, e.y, e.d);
            end
          end
        end
      end
    end
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Drive beats (index b = data) until the frame ends or reset is applied; gap=1 gives valid 1,0,0,1
  task automatic run_frame(input int gap, input int start_beat, input int rst_beat,
                           input int eol_beat, input int sof_beat, input bit start_in_done,
                           output bit timeout);
    int b;
    bit v;
    b = 0;
    timeout = 1'b1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      v = (gap == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      pix.s_valid = v;
      pix.s_data  = DW'(b);
      pix.s_sof   = (m_x == 0 && m_y == 0) || (b == sof_beat);
      pix.s_eol   = (m_x == W-1) ^ (b == eol_beat);
      start       = v && (b == start_beat);
      rst         = v && (b == rst_beat);
      tick();
      start = 1'b0;
      rst   = 1'b0;
      if (v) b++;
      if (m_st != 1) begin timeout = 1'b0; break; end
    end
    pix.s_valid = 1'b0;
    pix.s_sof   = 1'b0;
    pix.s_eol   = 1'b0;
    if (start_in_done && m_st == 2) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    n_vec++; if (wr_en !== 1'b0)   begin n_err++; $display("FAIL rst_wr_en got %b exp 0", wr_en); end
    n_vec++; if (busy !== 1'b0)    begin n_err++; $display("FAIL rst_busy got %b exp 0", busy); end
    n_vec++; if (done !== 1'b0)    begin n_err++; $display("FAIL rst_done got %b exp 0", done); end
    n_vec++; if (pix.s_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready got %b exp 0", pix.s_ready); end
    n_vec++; if (err !== 1'b0)     begin n_err++; $display("FAIL rst_err got %b exp 0", err); end
    n_vec++; if (waddr_0 !== '0 || waddr_1 !== '0 || wdata !== '0) begin
      n_err++; $display("FAIL rst_bus got (%0d,%0d)=%0d exp (0,0)=0", waddr_0, waddr_1, wdata);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_nominal();
    bit to;
    obs.delete(); done_seen = 0;
    start_frame();
    run_frame(0, -1, -1, -1, -1, 1'b0, to);
    n_vec++; if (to !== 1'b0) begin n_err++; $display("FAIL nom_timeout got 1 exp 0"); end
    n_vec++; if (obs.size() != W*H) begin n_err++; $display("FAIL nom_count got %0d exp %0d", obs.size(), W*H); end
    for (int k = 0; k < obs.size() && k < W*H; k++) begin
      n_vec++;
      if (obs[k].x != k % W || obs[k].y != k / W || obs[k].d != k) begin
        n_err++; $display("FAIL nom_w%0d got (%0d,%0d)=%0d exp (%0d,%0d)=%0d", k, obs[k].x, obs[k].y, obs[k].d, k % W, k / W, k);
      end
    end
    n_vec++; if (done_seen != 1) begin n_err++; $display("FAIL nom_done got %0d exp 1", done_seen); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL nom_busy_after got %b exp 0", busy); end
  endtask

  task automatic test_backpressure();
    bit to;
    obs.delete(); done_seen = 0;
    start_frame();
    run_frame(1, -1, -1, -1, -1, 1'b0, to);
    n_vec++; if (to !== 1'b0) begin n_err++; $display("FAIL bp_timeout got 1 exp 0"); end
    n_vec++; if (obs.size() != W*H) begin n_err++; $display("FAIL bp_count got %0d exp %0d", obs.size(), W*H); end
    for (int k = 0; k < obs.size() && k < W*H; k++) begin
      n_vec++;
      if (obs[k].x != k % W || obs[k].y != k / W) begin
        n_err++; $display("FAIL bp_w%0d got (%0d,%0d) exp (%0d,%0d)", k, obs[k].x, obs[k].y, k % W, k / W);
      end
    end
    n_vec++; if (done_seen != 1) begin n_err++; $display("FAIL bp_done got %0d exp 1", done_seen); end
  endtask

  task automatic test_idle_start();
    bit to;
    obs.delete(); done_seen = 0;
    pix.s_valid = 1'b1; pix.s_data = 8'd99;
    tick(); tick(); tick();
    n_vec++; if (obs.size() != 0) begin n_err++; $display("FAIL idle_writes got %0d exp 0", obs.size()); end
    n_vec++; if (pix.s_ready !== 1'b0) begin n_err++; $display("FAIL idle_ready got %b exp 0", pix.s_ready); end
    start_frame();
    run_frame(0, 10, -1, -1, -1, 1'b0, to);
    n_vec++; if (to !== 1'b0) begin n_err++; $display("FAIL idle_timeout got 1 exp 0"); end
    n_vec++; if (obs.size() != W*H) begin n_err++; $display("FAIL idle_count got %0d exp %0d", obs.size(), W*H); end
    for (int k = 0; k < obs.size() && k < W*H; k++) begin
      n_vec++;
      if (obs[k].x != k % W || obs[k].y != k / W || obs[k].d != k) begin
        n_err++; $display("FAIL idle_w%0d got (%0d,%0d)=%0d exp (%0d,%0d)=%0d", k, obs[k].x, obs[k].y, obs[k].d, k % W, k / W, k);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    obs.delete(); done_seen = 0;
    start_frame();
    run_frame(0, -1, 13, -1, -1, 1'b0, to);
    n_vec++; if (obs.size() != 13) begin n_err++; $display("FAIL rmid_count got %0d exp 13", obs.size()); end
    n_vec++; if (busy !== 1'b0 || wr_en !== 1'b0) begin n_err++; $display("FAIL rmid_idle got busy=%b wr_en=%b exp 0 0", busy, wr_en); end
    n_vec++; if (done_seen != 0) begin n_err++; $display("FAIL rmid_done got %0d exp 0", done_seen); end
    obs.delete(); exp_q.delete();
    start_frame();
    run_frame(0, -1, -1, -1, -1, 1'b0, to);
    n_vec++; if (obs.size() != W*H) begin n_err++; $display("FAIL rmid_count2 got %0d exp %0d", obs.size(), W*H); end
    n_vec++;
    if (obs.size() == 0 || obs[0].x != 0 || obs[0].y != 0 || obs[0].d != 0) begin
      n_err++; $display("FAIL rmid_first got size=%0d exp first write (0,0)=0", obs.size());
    end
    n_vec++; if (done_seen != 1) begin n_err++; $display("FAIL rmid_done2 got %0d exp 1", done_seen); end
  endtask

  task automatic test_sync();
    bit to;
    int x20, y20, x21, y21, n;
    obs.delete(); done_seen = 0;
    x20 = SYNC ? 0 : 4; y20 = SYNC ? 0 : 2;
    x21 = SYNC ? 1 : 5; y21 = SYNC ? 0 : 2;
    n   = SYNC ? 52 : 32;
    start_frame();
    run_frame(0, -1, -1, 13, 20, 1'b0, to);
    n_vec++; if (to !== 1'b0) begin n_err++; $display("FAIL sync_timeout got 1 exp 0"); end
    n_vec++; if (obs.size() != n) begin n_err++; $display("FAIL sync_count got %0d exp %0d", obs.size(), n); end
    if (obs.size() > 21) begin
      n_vec++; if (obs[13].x != 5 || obs[13].y != 1) begin n_err++; $display("FAIL sync_w13 got (%0d,%0d) exp (5,1)", obs[13].x, obs[13].y); end
      n_vec++; if (obs[20].x != x20 || obs[20].y != y20) begin n_err++; $display("FAIL sync_w20 got (%0d,%0d) exp (%0d,%0d)", obs[20].x, obs[20].y, x20, y20); end
      n_vec++; if (obs[21].x != x21 || obs[21].y != y21) begin n_err++; $display("FAIL sync_w21 got (%0d,%0d) exp (%0d,%0d)", obs[21].x, obs[21].y, x21, y21); end
    end
    n_vec++; if (err !== SYNC) begin n_err++; $display("FAIL sync_err got %b exp %b", err, SYNC); end
    n_vec++; if (done_seen != 1) begin n_err++; $display("FAIL sync_done got %0d exp 1", done_seen); end
  endtask

  task automatic test_back_to_back();
    bit to;
    obs.delete(); done_seen = 0;
    start_frame();
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL b2b_err_clear got %b exp 0", err); end
    run_frame(0, -1, -1, -1, -1, 1'b1, to);
    n_vec++; if (to !== 1'b0) begin n_err++; $display("FAIL b2b_timeout got 1 exp 0"); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_busy got %b exp 0", busy); end
    start_frame();
    run_frame(0, -1, -1, -1, -1, 1'b0, to);
    n_vec++; if (obs.size() != 2*W*H) begin n_err++; $display("FAIL b2b_count got %0d exp %0d", obs.size(), 2*W*H); end
    n_vec++; if (done_seen != 2) begin n_err++; $display("FAIL b2b_done got %0d exp 2", done_seen); end
    n_vec++;
    if (obs.size() > W*H && (obs[W*H].x != 0 || obs[W*H].y != 0)) begin
      n_err++; $display("FAIL b2b_first2 got (%0d,%0d) exp (0,0)", obs[W*H].x, obs[W*H].y);
    end
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL b2b_pending got %0d exp 0", exp_q.size()); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    pix.s_valid = 1'b0; pix.s_data = '0; pix.s_sof = 1'b0; pix.s_eol = 1'b0;
    m_st = 0; m_x = 0; m_y = 0; m_err = 1'b0; exp_wr = 1'b0;
    n_vec = 0; n_err = 0; done_seen = 0;
    mon_en = 1'b1;
    fork
      monitor();
    join_none
    test_reset();
    test_nominal();
    test_backpressure();
    test_idle_start();
    test_reset_mid();
    test_sync();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
